// File: rtl/char.sv
// CHAR: 30-bit binary magnitude to ten MIX character codes (30..39) via double dabble.
// Optional macro CHAR_FAST_EN: two add-3/shift steps per clock (15 edges instead of 30).
module char (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [29:0] in,
    output logic [59:0] out,
    output logic        busy,
    output logic        stop
);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

`ifdef CHAR_FAST_EN
    localparam logic [4:0] LAST_STEP = 5'd14;
`else
    localparam logic [4:0] LAST_STEP = 5'd29;
`endif

    state_t      state_r;
    logic [4:0]  cnt_r;
    logic [39:0] bcd_r;
    logic [29:0] bin_r;
    logic [69:0] next_s;

    // One double-dabble step on {bcd, bin}: correct nibbles >= 5, then shift left.
    function automatic logic [69:0] dd_step(input logic [69:0] v);
        logic [69:0] t;
        t = v;
        for (int i = 0; i < 10; i++) begin
            if (t[30+4*i +: 4] >= 4'd5) begin
                t[30+4*i +: 4] = t[30+4*i +: 4] + 4'd3;
            end else begin
                t[30+4*i +: 4] = t[30+4*i +: 4];
            end
        end
        return {t[68:0], 1'b0};
    endfunction

    // Next {bcd, bin} value for the current edge.
    always_comb begin
        next_s = {70{1'b0}};
`ifdef CHAR_FAST_EN
        next_s = dd_step(dd_step({bcd_r, bin_r}));
`else
        next_s = dd_step({bcd_r, bin_r});
`endif
    end

    // Each BCD digit becomes code 30+d; digit 9 lands in out[59:54].
    always_comb begin
        out = {60{1'b0}};
        for (int i = 0; i < 10; i++) begin
            out[6*i +: 6] = {2'b00, bcd_r[4*i +: 4]} + 6'd30;
        end
    end

    // Control FSM and datapath; start always (re)loads, even while running.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            stop    <= 1'b0;
            cnt_r   <= 5'd0;
            bcd_r   <= 40'd0;
            bin_r   <= 30'd0;
        end else begin
            stop <= 1'b0;
            if (start) begin
                state_r <= RUN;
                busy    <= 1'b1;
                cnt_r   <= 5'd0;
                bcd_r   <= 40'd0;
                bin_r   <= in;
            end else begin
                case (state_r)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    RUN: begin
                        bcd_r <= next_s[69:30];
                        bin_r <= next_s[29:0];
                        cnt_r <= cnt_r + 5'd1;
                        if (cnt_r == LAST_STEP) begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                            stop    <= 1'b1;
                        end else begin
                            busy    <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_char.sv
// Self-checking bench for char: directed sequence with a queue of expected codes.
module tb_char;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [29:0] in;
    logic [59:0] out;
    logic        busy;
    logic        stop;

    int checks = 0;
    int failures = 0;
    logic [59:0] exp_q[$];

`ifdef CHAR_FAST_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 31;
`endif

    char dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .in   (in),
        .out  (out),
        .busy (busy),
        .stop (stop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [59:0] obs, input logic [59:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoding by repeated division, least significant digit first.
    function automatic logic [59:0] enc(input logic [29:0] v);
        logic [59:0] r;
        int unsigned x;
        x = v;
        r = 60'd0;
        for (int i = 0; i < 10; i++) begin
            r[6*i +: 6] = 6'd30 + 6'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; afterwards the bench sits in cycle 1.
    task automatic launch(input logic [29:0] v, input bit push);
        start = 1'b1;
        in    = v;
        if (push) exp_q.push_back(enc(v));
        tick();
        start = 1'b0;
    endtask

    // From cycle 1, run to the stop cycle (bounded) while wiggling `in`; stays in the stop cycle.
    task automatic finish_conv(input string tag);
        int n;
        logic [59:0] e;
        n = 1;
        check({tag, "_busy_c1"}, 60'(busy), 60'd1);
        check({tag, "_stop_c1"}, 60'(stop), 60'd0);
        while (stop !== 1'b1 && n < 200) begin
            in = 30'($urandom);
            tick();
            n++;
        end
        check({tag, "_latency"}, 60'(n), 60'(LAT));
        check({tag, "_busy_stop"}, 60'(busy), 60'd0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 60'bx;
        check({tag, "_out"}, out, e);
    endtask

    initial begin
        logic [59:0] held;
        int stops;
        rst_n = 1'b0;
        start = 1'b0;
        in    = 30'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset_busy", 60'(busy), 60'd0);
        check("reset_stop", 60'(stop), 60'd0);
        check("reset_out", out, enc(30'd0));

        // Basic conversion, then stop drops and the result is held.
        launch(30'd12345, 1'b1);
        finish_conv("c12345");
        held = out;
        tick();
        check("c12345_stop_low", 60'(stop), 60'd0);
        in = 30'd999999;
        repeat (3) tick();
        check("c12345_hold", out, held);

        launch(30'd1073741823, 1'b1);
        finish_conv("cmax");

        launch(30'd0, 1'b1);
        finish_conv("czero");

        // Restart during RUN: the first request is abandoned.
        launch(30'd999, 1'b0);
        repeat (9) tick();
        check("abort_busy_c10", 60'(busy), 60'd1);
        launch(30'd5, 1'b1);
        finish_conv("abort");

        // Start in the stop cycle is accepted.
        launch(30'd42, 1'b1);
        finish_conv("chain_a");
        check("chain_stop_now", 60'(stop), 60'd1);
        launch(30'd907050301, 1'b1);
        finish_conv("chain_b");

        // Reset mid-conversion.
        launch(30'd777, 1'b0);
        repeat (14) tick();
        rst_n = 1'b0;
        tick();
        check("rst_mid_busy", 60'(busy), 60'd0);
        check("rst_mid_stop", 60'(stop), 60'd0);
        check("rst_mid_out", out, enc(30'd0));
        rst_n = 1'b1;
        stops = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (stop === 1'b1) stops++;
        end
        check("rst_mid_no_stop", 60'(stops), 60'd0);
        check("rst_mid_out_after", out, enc(30'd0));

        // Reset has priority over start.
        rst_n = 1'b0;
        start = 1'b1;
        in    = 30'd123;
        tick();
        start = 1'b0;
        rst_n = 1'b1;
        check("rst_prio_busy", 60'(busy), 60'd0);

        check("sb_empty", 60'(exp_q.size()), 60'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/char.md
CHAR -- requirements
Module: char

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-003 SHALL have port start, input, 1, one-cycle request to convert `in`, sampled on the same clk edge.
REQ-004 SHALL have port in, input, 30, unsigned magnitude of rA (bytes 1-5), range 0..1073741823.
REQ-005 SHALL have port out, output, 60, ten 6-bit MIX character codes, most significant digit in out[59:54]; upper 30 bits go to rA, lower 30 bits go to rX.
REQ-006 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-007 SHALL have port stop, output, 1, one-cycle pulse marking completion.

Function
REQ-008 SHALL convert `in` to 10 decimal digits using shift-and-add-3 (double dabble) over 30 binary-to-BCD steps.
REQ-009 SHALL encode each digit d as 6'd30+d (30..39), with leading zeros encoded as 30.
REQ-010 SHALL sample `in` only at a clk edge where start=1; changes to `in` at any other time SHALL have no effect.
REQ-011 State machine SHALL have states IDLE and RUN:
  - IDLE->RUN on start;
  - RUN->IDLE after the final step;
  - in RUN, start SHALL restart the conversion.
REQ-012 The start edge SHALL load the shift register, clear the BCD register and the step counter, and set busy=1.
REQ-013 SHALL perform exactly one step per edge in RUN: add 3 to each BCD nibble >=5, then shift {bcd,bin} left by 1.
REQ-014 With start sampled at the end of cycle 0:
  - steps SHALL occur at the edges ending cycles 1..30;
  - busy SHALL be high in cycles 1..30;
  - stop SHALL be high in cycle 31 only.
REQ-015 out SHALL be driven combinationally from the BCD register.
  - valid from the stop cycle;
  - held stable until the next start or reset;
  - intermediate values during RUN are undefined to consumers.
REQ-016 A start in RUN SHALL abort the current conversion without a stop pulse; timing then restarts from REQ-014 with the new `in`.
REQ-017 A start in the same cycle as stop SHALL be accepted; stop still pulses in that cycle.
REQ-018 Any BCD nibble SHALL never exceed 9 after a step, so no overflow or carry-out exists.
REQ-019 Sign handling SHALL be excluded: the sign bits of rA/rX are preserved outside this block.

Reset
REQ-020 While rst_n=0 at an edge, the block SHALL enter IDLE with busy=0, stop=0, step counter=0 and BCD register=0.
  - out therefore reads ten codes of 30.
REQ-021 rst_n=0 SHALL take priority over start.
REQ-022 Reset mid-conversion SHALL abort the conversion with no stop pulse.

Configuration
REQ-023 Macro CHAR_FAST_EN, if defined, SHALL make the block perform two double-dabble steps per edge (add-3/shift applied twice combinationally).
  - 15 edges per conversion;
  - busy high in cycles 1..15;
  - stop high in cycle 16.
REQ-024 If CHAR_FAST_EN is undefined, the block SHALL follow REQ-014 (30 steps, stop in cycle 31).
REQ-025 Results SHALL be bit-identical in both configurations.

Verification
REQ-026 rst_n=0 then release, no start -> busy=0, stop=0, out=ten bytes of 30.
REQ-027 start with in=12345 -> stop only in cycle 31; out bytes=30,30,30,30,30,31,32,33,34,35.
REQ-028 start with in=1073741823 -> out bytes=31,30,37,33,37,34,31,38,32,33.
REQ-029 start with in=999, then start with in=5 in cycle 10 -> no stop in cycle 31; single stop 31 cycles after the second start; out bytes=30 x9, then 35.
REQ-030 start with in=777, rst_n=0 in cycle 15 -> busy=0 from cycle 16; no stop; out=ten 30s.
REQ-031 CHAR_FAST_EN defined, start with in=0 -> stop in cycle 16 only; out=ten 30s; repeat REQ-028 -> same result.
